// File: rtl/ysyx_23060184_lsu_mem_stage_if.sv
// Memory-side bus of the MEM-stage LSU: req/gnt issue phase, rvalid response phase.
// The LSU is the master; the data memory or its arbiter is the slave.
interface ysyx_23060184_lsu_mem_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060184_lsu_mem_stage.sv
// MEM-stage load/store unit: one instruction per Evalid/Mready handshake, at most one
// req/gnt/rvalid transaction, lane selection, load extension and store strobes.
module ysyx_23060184_lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 192
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Evalid,
    output logic                  Mready,
    input  logic                  MemReadE,
    input  logic                  MemWriteE,
    input  logic [2:0]            Funct3E,
    input  logic [DATA_WIDTH-1:0] AddrE,
    input  logic [DATA_WIDTH-1:0] WDataE,
    input  logic [SB_WIDTH-1:0]   SidebandE,
    output logic                  Mvalid,
    input  logic                  Wready,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic [SB_WIDTH-1:0]   SidebandM,
    output logic                  MisalignM,
    ysyx_23060184_lsu_mem_stage_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state, next_state, accept_target;

    logic                  accept;
    logic                  is_load, is_store, is_mem, misalign;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [3:0]            strb_lane;

    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  load_q;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    assign Mready  = (state == IDLE) | ((state == DONE) & Wready);
    assign accept  = Evalid & Mready;
    assign Mvalid  = (state == DONE);
    assign bus.mem_req = (state == REQ);

    // A load wins if both MemReadE and MemWriteE are set.
    always_comb begin
        is_load  = MemReadE;
        is_store = MemWriteE & ~MemReadE;
        is_mem   = is_load | is_store;
        misalign = is_mem &
                   (((Funct3E[1:0] == 2'b01) & AddrE[0]) |
                    ((Funct3E[1:0] == 2'b10) & (AddrE[1:0] != 2'b00)));
        accept_target = (is_mem & ~misalign) ? REQ : DONE;
    end

    always_comb begin
        wdata_lane = WDataE;
        strb_lane  = 4'b1111;
        case (Funct3E[1:0])
            2'b00: begin
                wdata_lane = {4{WDataE[7:0]}};
                strb_lane  = 4'b0001 << AddrE[1:0];
            end
            2'b01: begin
                wdata_lane = {2{WDataE[15:0]}};
                strb_lane  = 4'b0011 << AddrE[1:0];
            end
            default: begin
                wdata_lane = WDataE;
                strb_lane  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rdata_shifted = bus.mem_rdata >> {addr_lo_q, 3'b000};
        load_ext      = rdata_shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shifted[7]}},  rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'h0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = accept_target;
            REQ:  if (bus.mem_gnt) next_state = WAIT;
            WAIT: if (bus.mem_rvalid) next_state = DONE;
            DONE: if (Wready) next_state = accept ? accept_target : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ReadDataM     <= '0;
            SidebandM     <= '0;
            MisalignM     <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_wstrb <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            load_q        <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                SidebandM     <= SidebandE;
                ReadDataM     <= '0;
                MisalignM     <= misalign;
                funct3_q      <= Funct3E;
                addr_lo_q     <= AddrE[1:0];
                load_q        <= is_load;
                bus.mem_addr  <= {AddrE[DATA_WIDTH-1:2], 2'b00};
                bus.mem_we    <= is_store & ~misalign;
                bus.mem_wdata <= is_store ? wdata_lane : '0;
                bus.mem_wstrb <= (is_store & ~misalign) ? strb_lane : 4'b0000;
            end else if ((state == WAIT) && bus.mem_rvalid && load_q) begin
                ReadDataM <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu_mem_stage.sv
// Directed testbench for the MEM-stage LSU with hand-computed expectations.
module tb_ysyx_23060184_lsu_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         Evalid, Mready, MemReadE, MemWriteE;
    logic [2:0]   Funct3E;
    logic [31:0]  AddrE, WDataE, ReadDataM;
    logic [191:0] SidebandE, SidebandM;
    logic         Mvalid, Wready, MisalignM;

    int total  = 0;
    int passed = 0;

    localparam logic [191:0] SB_A = {6{32'hA5A5_0001}};
    localparam logic [191:0] SB_B = {6{32'hB0B0_0002}};
    localparam logic [191:0] SB_C = {6{32'hC3C3_0003}};
    localparam logic [191:0] SB_D = {6{32'hD4D4_0004}};
    localparam logic [191:0] SB_E = {6{32'hE5E5_0005}};
    localparam logic [191:0] SB_F = {6{32'hF6F6_0006}};

    always #5 clk = ~clk;

    ysyx_23060184_lsu_mem_stage_if #(.DATA_WIDTH(32)) bus ();

    ysyx_23060184_lsu_mem_stage #(
        .DATA_WIDTH(32),
        .SB_WIDTH  (192)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Evalid    (Evalid),
        .Mready    (Mready),
        .MemReadE  (MemReadE),
        .MemWriteE (MemWriteE),
        .Funct3E   (Funct3E),
        .AddrE     (AddrE),
        .WDataE    (WDataE),
        .SidebandE (SidebandE),
        .Mvalid    (Mvalid),
        .Wready    (Wready),
        .ReadDataM (ReadDataM),
        .SidebandM (SidebandM),
        .MisalignM (MisalignM),
        .bus       (bus.master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        Evalid         = 1'b0;
        MemReadE       = 1'b0;
        MemWriteE      = 1'b0;
        Funct3E        = 3'b000;
        AddrE          = '0;
        WDataE         = '0;
        SidebandE      = '0;
        Wready         = 1'b1;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [191:0] sb);
        Evalid    = 1'b1;
        MemReadE  = rd;
        MemWriteE = wr;
        Funct3E   = f3;
        AddrE     = a;
        WDataE    = wd;
        SidebandE = sb;
    endtask

    // Grant in the first cycle, respond in the second; leaves the LSU in DONE.
    task automatic mem_handshake(input logic [31:0] rd);
        bus.mem_gnt    = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rd;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        tick();
        total++; if (Mvalid !== 1'b0) $display("FAIL reset_mvalid: got %b want 0", Mvalid); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.mem_we); else passed++;
        total++; if (MisalignM !== 1'b0) $display("FAIL reset_misalign: got %b want 0", MisalignM); else passed++;
        total++; if (ReadDataM !== 32'h0) $display("FAIL reset_rdata: got %h want 0", ReadDataM); else passed++;
        total++; if (SidebandM !== 192'h0) $display("FAIL reset_sideband: got %h want 0", SidebandM); else passed++;
        total++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 68'h0)
            $display("FAIL reset_bus_fields: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_wstrb); else passed++;
        reset = 1'b0;
        tick();
        total++; if (Mready !== 1'b1) $display("FAIL reset_mready: got %b want 1", Mready); else passed++;
    endtask

    task automatic test_alu_op();
        issue(1'b0, 1'b0, 3'b000, 32'h1234_5677, 32'h0, SB_A);
        #1;
        total++; if (Mready !== 1'b1) $display("FAIL alu_mready: got %b want 1", Mready); else passed++;
        tick();
        Evalid = 1'b0;
        total++; if (Mvalid !== 1'b1) $display("FAIL alu_mvalid: got %b want 1", Mvalid); else passed++;
        total++; if (ReadDataM !== 32'h0) $display("FAIL alu_rdata: got %h want 0", ReadDataM); else passed++;
        total++; if (SidebandM !== SB_A) $display("FAIL alu_sideband: got %h want %h", SidebandM, SB_A); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL alu_no_req: got %b want 0", bus.mem_req); else passed++;
        tick();
        total++; if (Mvalid !== 1'b0) $display("FAIL alu_idle_after: got %b want 0", Mvalid); else passed++;
    endtask

    task automatic test_load();
        issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, SB_B);
        tick();
        Evalid = 1'b0;
        total++; if (bus.mem_req !== 1'b1) $display("FAIL lb_req: got %b want 1", bus.mem_req); else passed++;
        total++; if (bus.mem_addr !== 32'h8000_0000) $display("FAIL lb_addr: got %h want 80000000", bus.mem_addr); else passed++;
        total++; if ({bus.mem_we, bus.mem_wstrb} !== 5'b0) $display("FAIL lb_we_strb: got %b %b want 0 0000", bus.mem_we, bus.mem_wstrb); else passed++;
        total++; if (Mready !== 1'b0) $display("FAIL lb_mready_busy: got %b want 0", Mready); else passed++;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h80FF_1234;
        total++; if ({bus.mem_req, Mvalid} !== 2'b00) $display("FAIL lb_wait: got req=%b mvalid=%b want 0 0", bus.mem_req, Mvalid); else passed++;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        total++; if (Mvalid !== 1'b1) $display("FAIL lb_mvalid_n3: got %b want 1", Mvalid); else passed++;
        total++; if (ReadDataM !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", ReadDataM); else passed++;
        total++; if (SidebandM !== SB_B) $display("FAIL lb_sideband: got %h want %h", SidebandM, SB_B); else passed++;
        tick();

        issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, SB_B);
        tick();
        Evalid = 1'b0;
        mem_handshake(32'h80FF_1234);
        total++; if (ReadDataM !== 32'h0000_80FF) $display("FAIL lhu_data: got %h want 000080ff", ReadDataM); else passed++;
        tick();

        issue(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, SB_B);
        tick();
        Evalid = 1'b0;
        mem_handshake(32'h1234_F00D);
        total++; if (ReadDataM !== 32'hFFFF_F00D) $display("FAIL lh_data: got %h want fffff00d", ReadDataM); else passed++;
        tick();

        issue(1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0, SB_B);
        tick();
        Evalid = 1'b0;
        mem_handshake(32'h80FF_9234);
        total++; if (ReadDataM !== 32'h0000_0092) $display("FAIL lbu_data: got %h want 00000092", ReadDataM); else passed++;
        tick();

        issue(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, SB_B);
        tick();
        Evalid = 1'b0;
        total++; if (bus.mem_addr !== 32'h8000_0004) $display("FAIL lw_addr: got %h want 80000004", bus.mem_addr); else passed++;
        mem_handshake(32'hCAFE_BABE);
        total++; if (ReadDataM !== 32'hCAFE_BABE) $display("FAIL lw_data: got %h want cafebabe", ReadDataM); else passed++;
        tick();
    endtask

    task automatic test_store();
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hABCD_1234, SB_C);
        tick();
        Evalid = 1'b0;
        total++; if (bus.mem_req !== 1'b1) $display("FAIL sh_req: got %b want 1", bus.mem_req); else passed++;
        total++; if (bus.mem_we !== 1'b1) $display("FAIL sh_we: got %b want 1", bus.mem_we); else passed++;
        total++; if (bus.mem_wdata !== 32'h1234_1234) $display("FAIL sh_wdata: got %h want 12341234", bus.mem_wdata); else passed++;
        total++; if (bus.mem_wstrb !== 4'b1100) $display("FAIL sh_wstrb: got %b want 1100", bus.mem_wstrb); else passed++;
        total++; if (bus.mem_addr !== 32'h8000_0000) $display("FAIL sh_addr: got %h want 80000000", bus.mem_addr); else passed++;
        mem_handshake(32'hFFFF_FFFF);
        total++; if (Mvalid !== 1'b1) $display("FAIL sh_done: got %b want 1", Mvalid); else passed++;
        total++; if (ReadDataM !== 32'h0) $display("FAIL sh_rdata_zero: got %h want 0", ReadDataM); else passed++;
        tick();

        issue(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5, SB_C);
        tick();
        Evalid = 1'b0;
        total++; if (bus.mem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", bus.mem_wdata); else passed++;
        total++; if (bus.mem_wstrb !== 4'b0010) $display("FAIL sb_wstrb: got %b want 0010", bus.mem_wstrb); else passed++;
        mem_handshake(32'h0);
        tick();
    endtask

    task automatic test_gnt_stall();
        issue(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, SB_D);
        tick();
        // A different instruction waits in EX/MEM, and a stray rvalid appears while stalled.
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, SB_E);
        bus.mem_rvalid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
                {1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111})
                $display("FAIL stall_bus_stable cycle %0d: got req=%b we=%b addr=%h wdata=%h wstrb=%b want 1 1 80000010 deadbeef 1111",
                         i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
            else passed++;
            total++; if (Mready !== 1'b0) $display("FAIL stall_mready cycle %0d: got %b want 0", i, Mready); else passed++;
            tick();
        end
        bus.mem_rvalid = 1'b0;
        Evalid = 1'b0;
        mem_handshake(32'h0);
        total++; if (Mvalid !== 1'b1) $display("FAIL stall_done: got %b want 1", Mvalid); else passed++;
        total++; if (SidebandM !== SB_D) $display("FAIL stall_sideband: got %h want %h", SidebandM, SB_D); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, SB_C);
        tick();
        Evalid = 1'b0;
        Wready = 1'b0;
        mem_handshake(32'h1122_3344);
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({Mvalid, ReadDataM, SidebandM} !== {1'b1, 32'h1122_3344, SB_C})
                $display("FAIL hold_outputs cycle %0d: got mvalid=%b rdata=%h want 1 11223344", i, Mvalid, ReadDataM);
            else passed++;
            total++; if (Mready !== 1'b0) $display("FAIL hold_mready cycle %0d: got %b want 0", i, Mready); else passed++;
            tick();
        end
        Wready = 1'b1;
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, SB_D);
        #1;
        total++; if (Mready !== 1'b1) $display("FAIL b2b_mready: got %b want 1", Mready); else passed++;
        tick();
        Evalid = 1'b0;
        total++; if (Mvalid !== 1'b1) $display("FAIL b2b_mvalid: got %b want 1", Mvalid); else passed++;
        total++; if (SidebandM !== SB_D) $display("FAIL b2b_sideband: got %h want %h", SidebandM, SB_D); else passed++;
        total++; if (ReadDataM !== 32'h0) $display("FAIL b2b_rdata: got %h want 0", ReadDataM); else passed++;
        tick();
        total++; if (Mvalid !== 1'b0) $display("FAIL b2b_idle_after: got %b want 0", Mvalid); else passed++;
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, SB_E);
        tick();
        Evalid = 1'b0;
        total++; if (Mvalid !== 1'b1) $display("FAIL mis_lw_mvalid: got %b want 1", Mvalid); else passed++;
        total++; if (MisalignM !== 1'b1) $display("FAIL mis_lw_flag: got %b want 1", MisalignM); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL mis_lw_no_req: got %b want 0", bus.mem_req); else passed++;
        total++; if (SidebandM !== SB_E) $display("FAIL mis_lw_sideband: got %h want %h", SidebandM, SB_E); else passed++;
        tick();
        issue(1'b1, 1'b0, 3'b001, 32'h8000_0003, 32'h0, SB_E);
        tick();
        Evalid = 1'b0;
        total++; if ({MisalignM, bus.mem_req} !== 2'b10) $display("FAIL mis_lh: got flag=%b req=%b want 1 0", MisalignM, bus.mem_req); else passed++;
        tick();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, SB_A);
        tick();
        Evalid = 1'b0;
        total++; if (MisalignM !== 1'b0) $display("FAIL mis_clear: got %b want 0", MisalignM); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 3'b010, 32'h8000_0040, 32'h0, SB_F);
        tick();
        Evalid = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        total++; if ({Mvalid, bus.mem_req, Mready} !== 3'b001)
            $display("FAIL rst_mid_idle: got mvalid=%b req=%b mready=%b want 0 0 1", Mvalid, bus.mem_req, Mready); else passed++;
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        total++; if (Mvalid !== 1'b0) $display("FAIL rst_stale_rvalid: got %b want 0", Mvalid); else passed++;
        total++; if (ReadDataM !== 32'h0) $display("FAIL rst_stale_rdata: got %h want 0", ReadDataM); else passed++;
        tick();
        total++; if (Mvalid !== 1'b0) $display("FAIL rst_no_late_mvalid: got %b want 0", Mvalid); else passed++;
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, SB_F);
        tick();
        Evalid = 1'b0;
        total++; if ({Mvalid, SidebandM} !== {1'b1, SB_F}) $display("FAIL rst_recover: got mvalid=%b sb=%h want 1 %h", Mvalid, SidebandM, SB_F); else passed++;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_gnt_stall();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
